// File: rtl/load_line_pkg.sv
// Shared system-bus definitions: FSM state encoding for the line
// fetchers, bus opcode / target codes and the cache-line offset width.
// Used by load_line and store_data.
//
// Contents:
//   sysbus_state_t  - IDLE / ARB / ADDR / RESP / READY
//   SYSBUS_READ, SYSBUS_WRITE, SYSBUS_MEMORY - tag fields
//   LINE_OFFSET_W   - byte offset bits within a 64-byte line
//   sysbus_tag()    - builds a request tag from opcode and target
package load_line_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        ADDR  = 3'd2,
        RESP  = 3'd3,
        READY = 3'd4
    } sysbus_state_t;

    localparam int unsigned SYSBUS_WRITE  = 0;
    localparam int unsigned SYSBUS_READ   = 1;
    localparam int unsigned SYSBUS_MEMORY = 1;
    localparam int unsigned LINE_OFFSET_W = 6;

    // Opcode lives in bits [15:12], target in bits [11:8].
    function automatic int unsigned sysbus_tag(input int unsigned op, input int unsigned target);
        return (op << 12) | (target << 8);
    endfunction

endpackage

// File: rtl/load_line_line_assembler.sv
// line_assembler: beat-indexed capture register for one cache line.
//
// Ports:
//   clk, reset - clock, synchronous active-high reset (clears line)
//   clear      - clears the whole line (start of a new fetch)
//   we, idx    - write beat into slot idx
//   beat       - incoming beat data
//   line       - assembled line, slot k at line[k*BEAT_WIDTH +: BEAT_WIDTH]
module line_assembler #(
    parameter int BEAT_WIDTH = 64,
    parameter int BEATS      = 8,
    parameter int IDX_W      = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        we,
    input  logic [IDX_W-1:0]            idx,
    input  logic [BEAT_WIDTH-1:0]       beat,
    output logic [BEATS*BEAT_WIDTH-1:0] line
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            line <= '0;
        end else if (we) begin
            for (int i = 0; i < BEATS; i++) begin
                if (idx == IDX_W'(i)) begin
                    line[i*BEAT_WIDTH +: BEAT_WIDTH] <= beat;
                end
            end
        end
    end

endmodule

// File: rtl/load_line.sv
// load_line: fetches one cache line over the system bus.
// Arbitrates for the bus, issues a line-aligned read request, collects
// BEATS response beats into a line register and presents it with ready.
//
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   enable, addr           - start a fetch (accepted in IDLE/READY), byte address
//   abtr_reqcyc/grant      - arbiter request / grant
//   main_bus_req*          - request channel (cyc, address, tag, ack)
//   main_bus_resp*         - response channel (cyc, data, tag, ack)
//   bus_busy               - high while the request/response is in flight
//   ready, data            - assembled line valid / line contents
//
// Build option: LOAD_LINE_TAG_CHECK_EN - only accept response beats whose
// tag matches the issued request tag; otherwise every beat is accepted.
//
// state | meaning
// IDLE  | no fetch, waiting for enable
// ARB   | requesting the bus from the arbiter
// ADDR  | driving the read request until reqack
// RESP  | collecting response beats
// READY | line valid, waiting for the next enable
module load_line
    import load_line_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [BUS_DATA_WIDTH-1:0]       addr,
    output logic                            abtr_reqcyc,
    input  logic                            abtr_grant,
    output logic                            main_bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]       main_bus_req,
    output logic [BUS_TAG_WIDTH-1:0]        main_bus_reqtag,
    input  logic                            main_bus_reqack,
    input  logic                            main_bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]       main_bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]        main_bus_resptag,
    output logic                            main_bus_respack,
    output logic                            bus_busy,
    output logic                            ready,
    output logic [BEATS*BUS_DATA_WIDTH-1:0] data
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [BUS_TAG_WIDTH-1:0] REQ_TAG =
        BUS_TAG_WIDTH'(sysbus_tag(SYSBUS_READ, SYSBUS_MEMORY));
    localparam logic [BUS_DATA_WIDTH-1:0] LINE_MASK =
        ~BUS_DATA_WIDTH'((1 << LINE_OFFSET_W) - 1);

    sysbus_state_t             state;
    logic [CNT_W-1:0]          beat_cnt;
    logic [BUS_DATA_WIDTH-1:0] addr_q;
    logic                      accept;
    logic                      tag_ok;
    logic                      beat_acc;

`ifdef LOAD_LINE_TAG_CHECK_EN
    assign tag_ok = (main_bus_resptag == REQ_TAG);
`else
    // Tag is not qualified in this build; the reduction only keeps the port consumed.
    assign tag_ok = 1'b1 | (^main_bus_resptag);
`endif

    assign accept           = enable && ((state == IDLE) || (state == READY));
    // Beat handshake is combinational so a beat is acked in the cycle it is offered.
    assign beat_acc         = (state == RESP) && main_bus_respcyc && tag_ok;
    assign main_bus_respack = beat_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            beat_cnt        <= '0;
            addr_q          <= '0;
            abtr_reqcyc     <= 1'b0;
            main_bus_reqcyc <= 1'b0;
            main_bus_req    <= '0;
            main_bus_reqtag <= '0;
            bus_busy        <= 1'b0;
            ready           <= 1'b0;
        end else begin
            case (state)
                IDLE, READY: begin
                    if (enable) begin
                        state       <= ARB;
                        addr_q      <= addr;
                        abtr_reqcyc <= 1'b1;
                        ready       <= 1'b0;
                    end
                end
                ARB: begin
                    if (abtr_grant) begin
                        state           <= ADDR;
                        abtr_reqcyc     <= 1'b0;
                        main_bus_reqcyc <= 1'b1;
                        main_bus_req    <= addr_q & LINE_MASK;
                        main_bus_reqtag <= REQ_TAG;
                        bus_busy        <= 1'b1;
                    end
                end
                ADDR: begin
                    if (main_bus_reqack) begin
                        state           <= RESP;
                        main_bus_reqcyc <= 1'b0;
                        main_bus_req    <= '0;
                        main_bus_reqtag <= '0;
                    end
                end
                RESP: begin
                    if (beat_acc) begin
                        if (beat_cnt == LAST_BEAT) begin
                            state    <= READY;
                            beat_cnt <= '0;
                            bus_busy <= 1'b0;
                            ready    <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A new fetch clears the line so stale beats never leak into it.
    line_assembler #(
        .BEAT_WIDTH (BUS_DATA_WIDTH),
        .BEATS      (BEATS),
        .IDX_W      (CNT_W)
    ) u_line_assembler (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .we    (beat_acc),
        .idx   (beat_cnt),
        .beat  (main_bus_resp),
        .line  (data)
    );

endmodule

// File: doc/load_line.md
LOAD_LINE -- requirements
Module: load_line

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64, meaning bus beat width in bits.
REQ-002 SHALL have parameter BUS_TAG_WIDTH, default 13, meaning request/response tag width.
REQ-003 SHALL have parameter BEATS, default 8, meaning data beats per line (line = BEATS*BUS_DATA_WIDTH = 512 bits).
REQ-004 SHALL have port clk, input, 1, system clock; all logic on posedge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1, start a line fetch when idle or ready.
REQ-007 SHALL have port addr, input, BUS_DATA_WIDTH, byte address; sampled on the accepting enable cycle.
REQ-008 SHALL have ports abtr_reqcyc (output, 1) and abtr_grant (input, 1), arbiter request and grant.
REQ-009 SHALL have ports main_bus_reqcyc (output, 1), main_bus_req (output, BUS_DATA_WIDTH), main_bus_reqtag (output, BUS_TAG_WIDTH) and main_bus_reqack (input, 1), request channel.
REQ-010 SHALL have ports main_bus_respcyc (input, 1), main_bus_resp (input, BUS_DATA_WIDTH), main_bus_resptag (input, BUS_TAG_WIDTH) and main_bus_respack (output, 1), response channel.
REQ-011 SHALL have ports bus_busy (output, 1), ready (output, 1) and data (output, BEATS*BUS_DATA_WIDTH), the assembled line.

Function
REQ-012 SHALL implement states IDLE, ARB, ADDR, RESP, READY.
REQ-013 SHALL transition IDLE->ARB on enable, and READY->ARB on enable; in all other states enable SHALL be ignored.
REQ-014 SHALL, in ARB, assert abtr_reqcyc and move to ADDR on the cycle after abtr_grant=1.
REQ-015 SHALL, in ADDR, assert main_bus_reqcyc and drive main_bus_req = {addr[63:6],6'b0} and main_bus_reqtag = READ<<12 | MEMORY<<8 (0x1100); it SHALL hold these until main_bus_reqack=1, then move to RESP.
REQ-016 SHALL, in RESP, deassert main_bus_reqcyc, and on each cycle with main_bus_respcyc=1 assert main_bus_respack combinationally in the same cycle and store main_bus_resp into data[64*k+:64], where k is the 3-bit beat counter.
REQ-017 SHALL increment the beat counter only on accepted beats; after beat BEATS-1 it SHALL move to READY, and the counter SHALL not wrap within a line.
REQ-018 SHALL, in READY, hold ready=1 and data stable until the next accepted enable; ready SHALL be 0 in every other state.
REQ-019 SHALL hold bus_busy=1 in ADDR and RESP and 0 otherwise.
REQ-020 SHALL tolerate bubbles: RESP cycles with respcyc=0 do not advance the counter, and there is no timeout.
REQ-021 SHALL give a minimum latency from enable to ready of 1 (ARB) + 1 (grant) + 1 (reqack) + 8 beats = 11 cycles.
REQ-022 SHALL keep main_bus_respack=0 outside RESP.

Reset
REQ-023 SHALL, on reset (including mid-fetch), enter IDLE and clear counter, data=0, ready=0, bus_busy=0, abtr_reqcyc=0, main_bus_reqcyc=0, main_bus_respack=0, main_bus_req=0 and main_bus_reqtag=0 the following cycle.
REQ-024 SHALL discard partial line contents on reset.

Configuration
REQ-025 SHALL, with LOAD_LINE_TAG_CHECK_EN defined, accept a RESP beat only if main_bus_resptag equals the issued request tag; mismatched beats get respack=0 and are not stored.
REQ-026 SHALL, without LOAD_LINE_TAG_CHECK_EN, accept every respcyc beat in RESP regardless of tag.

Structure
REQ-027 SHALL take the state enum, SYSBUS_READ/WRITE, SYSBUS_MEMORY and the line-offset width (6) from the shared sysbus package, also used by store_data.
REQ-028 SHALL support one optional sub-module, line_assembler: beat-indexed 512-bit capture register with clear and write-enable.

Verification
REQ-029 SHALL verify a basic fetch: addr=0x1047, grant after 2 cycles, reqack immediate, beats 0x11..0x88 back-to-back -> req=0x1040, tag=0x1100, data[63:0]=0x11, data[511:448]=0x88, ready at cycle 11 (from enable with grant 1 cycle after request).
REQ-030 SHALL verify bubbles: beats with respcyc=0 inserted between beats 3 and 4 -> counter holds, line identical, ready delayed by the bubble count.
REQ-031 SHALL verify a reqack stall of 5 cycles -> reqcyc/req/tag held constant for 5 cycles, no beat captured before reqack.
REQ-032 SHALL verify reset after beat 4 -> IDLE next cycle, all outputs 0; a new fetch returns a clean line.
REQ-033 SHALL verify TAG_CHECK_EN: a beat with resptag=0x0100 -> respack=0, counter unchanged; without the macro it is accepted.
REQ-034 SHALL verify enable held in RESP -> ignored; enable in READY -> ARB next cycle, ready drops.
